// File: rtl/core_run_ctrl.sv
// Run/halt/step controller for a single-issue core.
// Gates PC and register-file update and tracks the halt cause.
module core_run_ctrl #(
    parameter int unsigned HOLD_CYCLES  = 4,
    parameter bit          START_HALTED = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run_req,
    input  logic        halt_req,
    input  logic        step_req,
    input  logic [7:0]  step_count,
    input  logic        bp_en,
    input  logic [31:0] bp_addr,
    input  logic [31:0] pc,
    input  logic        core_halt,
    input  logic        cnt_clr,
    output logic        core_en,
    output logic [1:0]  state,
    output logic        halted,
    output logic [2:0]  halt_cause,
    output logic [7:0]  step_rem,
    output logic [31:0] cycle_cnt,
    output logic [31:0] retire_cnt
);

    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        S_HOLD   = 2'b00,
        S_HALTED = 2'b01,
        S_RUN    = 2'b10,
        S_STEP   = 2'b11
    } state_t;

    localparam logic [2:0] C_ECALL = 3'd1;
    localparam logic [2:0] C_EXT   = 3'd2;
    localparam logic [2:0] C_BP    = 3'd3;
    localparam logic [2:0] C_STEP  = 3'd4;

    state_t      state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [2:0]  cause_q, cause_d;
    logic [7:0]  rem_q, rem_d;
    logic        skip_q, skip_d;
    logic [31:0] cyc_q, ret_q;
    logic        active, bp_hit, stop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_HOLD;
            hold_q  <= '0;
            cause_q <= '0;
            rem_q   <= '0;
            skip_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            cause_q <= cause_d;
            rem_q   <= rem_d;
            skip_q  <= skip_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        cause_d = cause_q;
        rem_d   = rem_q;
        skip_d  = skip_q;
        active  = (state_q == S_RUN) || (state_q == S_STEP);
        bp_hit  = bp_en && (pc == bp_addr) && !skip_q;
        stop    = active && (core_halt || halt_req || bp_hit);
        core_en = active && !stop;
        // The resumed-at breakpoint instruction is allowed through once
        if (core_en) skip_d = 1'b0;
        unique case (state_q)
            S_HOLD: begin
                if (hold_q == HOLD_LAST) begin
                    hold_d  = '0;
                    state_d = START_HALTED ? S_HALTED : S_RUN;
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            S_HALTED: begin
                if (run_req) begin
                    state_d = S_RUN;
                    skip_d  = 1'b1;
                end else if (step_req && step_count != 8'd0) begin
                    state_d = S_STEP;
                    rem_d   = step_count;
                    skip_d  = 1'b1;
                end
            end
            S_RUN, S_STEP: begin
                if (stop) begin
                    state_d = S_HALTED;
                    cause_d = core_halt ? C_ECALL :
                              halt_req  ? C_EXT   : C_BP;
                end else if (state_q == S_STEP) begin
                    if (rem_q == 8'd1) begin
                        state_d = S_HALTED;
                        cause_d = C_STEP;
                        rem_d   = 8'd0;
                    end else begin
                        rem_d = rem_q - 8'd1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_q <= '0;
            ret_q <= '0;
        end else if (cnt_clr) begin
            cyc_q <= '0;
            ret_q <= '0;
        end else begin
            cyc_q <= cyc_q + {31'd0, state_q != S_HOLD};
            ret_q <= ret_q + {31'd0, core_en};
        end
    end

    assign state      = state_q;
    assign halted     = (state_q == S_HALTED);
    assign halt_cause = cause_q;
    assign step_rem   = rem_q;
    assign cycle_cnt  = cyc_q;
    assign retire_cnt = ret_q;

endmodule

// File: tb/tb_core_run_ctrl.sv
// Bench for core_run_ctrl: directed scenarios plus random stimulus
// checked every cycle against a behavioural model.
module tb_core_run_ctrl;

    localparam int HOLD = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run_req = 0, halt_req = 0, step_req = 0;
    logic [7:0]  step_count = 0;
    logic        bp_en = 0;
    logic [31:0] bp_addr = 0, pc = 0;
    logic        core_halt = 0, cnt_clr = 0;
    logic        core_en, halted;
    logic [1:0]  state;
    logic [2:0]  halt_cause;
    logic [7:0]  step_rem;
    logic [31:0] cycle_cnt, retire_cnt;

    int checks = 0;
    int errors = 0;

    core_run_ctrl #(.HOLD_CYCLES(HOLD), .START_HALTED(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .run_req(run_req), .halt_req(halt_req), .step_req(step_req),
        .step_count(step_count), .bp_en(bp_en), .bp_addr(bp_addr),
        .pc(pc), .core_halt(core_halt), .cnt_clr(cnt_clr),
        .core_en(core_en), .state(state), .halted(halted),
        .halt_cause(halt_cause), .step_rem(step_rem),
        .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Behavioural model: mode 0 hold, 1 halted, 2 run, 3 step
    int          m_mode, m_held;
    logic [2:0]  m_cause;
    logic [7:0]  m_rem;
    logic [31:0] m_cyc, m_ret;
    bit          m_skip;

    always @(negedge clk or negedge rst_n) begin
        bit go, hit, stp, en;
        if (!rst_n) begin
            m_mode = 0; m_held = 0; m_cause = 0;
            m_rem = 0; m_cyc = 0; m_ret = 0; m_skip = 0;
        end else begin
            go  = (m_mode >= 2);
            hit = bp_en && (pc == bp_addr) && !m_skip;
            stp = go && (core_halt || halt_req || hit);
            en  = go && !stp;
            chk("model_ctl", {22'd0, state, halted, core_en, halt_cause,
                              step_rem},
                {22'd0, 2'(m_mode), m_mode == 1, en, m_cause, m_rem});
            chk("model_cycle_cnt", cycle_cnt, m_cyc);
            chk("model_retire_cnt", retire_cnt, m_ret);
            if (cnt_clr) begin
                m_cyc = 0; m_ret = 0;
            end else begin
                m_cyc = m_cyc + (m_mode != 0 ? 1 : 0);
                m_ret = m_ret + (en ? 1 : 0);
            end
            if (en) m_skip = 0;
            if (m_mode == 0) begin
                m_held++;
                if (m_held == HOLD) begin
                    m_held = 0; m_mode = 1;
                end
            end else if (m_mode == 1) begin
                if (run_req) begin
                    m_mode = 2; m_skip = 1;
                end else if (step_req && step_count != 0) begin
                    m_mode = 3; m_skip = 1; m_rem = step_count;
                end
            end else if (stp) begin
                m_mode = 1;
                m_cause = core_halt ? 3'd1 : halt_req ? 3'd2 : 3'd3;
            end else if (m_mode == 3) begin
                m_rem = m_rem - 8'd1;
                if (m_rem == 0) begin
                    m_mode = 1; m_cause = 3'd4;
                end
            end
        end
    end

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic hold_seq();
        for (int i = 0; i < HOLD; i++) begin
            #1;
            chk("hold_state", 32'(state), 32'd0);
            chk("hold_en", 32'(core_en), 32'd0);
            step_clk();
        end
        #1;
        chk("post_hold_state", 32'(state), 32'd1);
        chk("post_hold_cause", 32'(halt_cause), 32'd0);
        chk("post_hold_cyc", cycle_cnt, 32'd0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        hold_seq();

        // step burst of 3
        step_req = 1; step_count = 8'd3;
        step_clk();
        step_req = 0;
        #1 chk("step_rem3", 32'(step_rem), 32'd3);
        chk("step_en3", 32'(core_en), 32'd1);
        step_clk();
        #1 chk("step_rem2", 32'(step_rem), 32'd2);
        step_clk();
        #1 chk("step_rem1", 32'(step_rem), 32'd1);
        chk("step_en1", 32'(core_en), 32'd1);
        step_clk();
        #1 chk("step_done_state", 32'(state), 32'd1);
        chk("step_done_cause", 32'(halt_cause), 32'd4);
        chk("step_done_rem", 32'(step_rem), 32'd0);
        chk("step_done_ret", retire_cnt, 32'd3);

        // breakpoint at 0x10
        bp_en = 1; bp_addr = 32'h10; pc = 32'h8; run_req = 1;
        step_clk();
        run_req = 0;
        #1 chk("bp_run_en", 32'(core_en), 32'd1);
        step_clk();
        pc = 32'h10;
        #1 chk("bp_hit_en", 32'(core_en), 32'd0);
        step_clk();
        #1 chk("bp_cause", 32'(halt_cause), 32'd3);
        run_req = 1;
        step_clk();
        run_req = 0;
        #1 chk("bp_resume_en", 32'(core_en), 32'd1);
        step_clk();
        pc = 32'h14;
        #1 chk("bp_left_en", 32'(core_en), 32'd1);
        step_clk();
        pc = 32'h10;
        #1 chk("bp_rehit_en", 32'(core_en), 32'd0);
        step_clk();
        #1 chk("bp_rehit_state", 32'(state), 32'd1);
        chk("bp_ret", retire_cnt, 32'd6);

        // ECALL beats EXT; run beats step
        bp_en = 0; run_req = 1;
        step_clk();
        run_req = 0; core_halt = 1; halt_req = 1;
        #1 chk("both_stop_en", 32'(core_en), 32'd0);
        step_clk();
        core_halt = 0; halt_req = 0;
        #1 chk("both_stop_cause", 32'(halt_cause), 32'd1);
        run_req = 1; step_req = 1; step_count = 8'd5;
        step_clk();
        run_req = 0; step_req = 0;
        #1 chk("run_prio_state", 32'(state), 32'd2);
        chk("run_prio_rem", 32'(step_rem), 32'd0);

        // counter clear
        cnt_clr = 1;
        step_clk();
        cnt_clr = 0;
        #1 chk("clr_cyc", cycle_cnt, 32'd0);
        chk("clr_ret", retire_cnt, 32'd0);
        step_clk();
        #1 chk("clr_cyc1", cycle_cnt, 32'd1);
        chk("clr_ret1", retire_cnt, 32'd1);

        // async reset mid-step
        halt_req = 1;
        step_clk();
        halt_req = 0; step_req = 1; step_count = 8'd9;
        step_clk();
        step_req = 0;
        repeat (4) step_clk();
        #1 chk("mid_step_rem", 32'(step_rem), 32'd5);
        #1 rst_n = 1'b0;
        #1 chk("rst_en", 32'(core_en), 32'd0);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_rem", 32'(step_rem), 32'd0);
        chk("rst_cnts", cycle_cnt | retire_cnt, 32'd0);
        step_clk();
        rst_n = 1'b1;
        hold_seq();

        // random phase
        for (int i = 0; i < 3000; i++) begin
            run_req    = ($urandom_range(0, 9) == 0);
            step_req   = ($urandom_range(0, 7) == 0);
            step_count = 8'($urandom_range(0, 6));
            halt_req   = ($urandom_range(0, 29) == 0);
            core_halt  = ($urandom_range(0, 39) == 0);
            cnt_clr    = ($urandom_range(0, 99) == 0);
            bp_en      = 1'($urandom_range(0, 1));
            bp_addr    = 32'h10;
            pc         = 32'h8 + 32'($urandom_range(0, 3)) * 4;
            rst_n      = (i != 1500);
            step_clk();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
